// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes one LSB or instruction-fetch request at a time into byte-wide
// accesses on the external RAM/IO bus and returns the result with a one-cycle done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for a request; LSB wins over fetch, none taken on rollback
// S_READ  | issuing byte addresses, capturing each byte one cycle later
// S_WRITE | writing one byte per cycle, held while the IO buffer is full
// S_DONE  | done pulse high for exactly this cycle
module mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback,
   input  logic              lsb_en,
   input  logic              lsb_wr,
   input  logic [ADDR_W-1:0] lsb_a,
   input  logic [2:0]        lsb_l,
   input  logic [DATA_W-1:0] lsb_w,
   output logic [DATA_W-1:0] lsb_r,
   output logic              lsb_done,
   input  logic              if_en,
   input  logic [ADDR_W-1:0] if_a,
   output logic [DATA_W-1:0] if_data,
   output logic              if_done,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        len_q, len_d;
   logic              src_if_q, src_if_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [7:0]        mem_dout_q, mem_dout_d;
   logic              mem_wr_q, mem_wr_d;
   logic [DATA_W-1:0] lsb_r_q, lsb_r_d;
   logic              lsb_done_q, lsb_done_d;
   logic [DATA_W-1:0] if_data_q, if_data_d;
   logic              if_done_q, if_done_d;

   logic       io_stall;
   logic [2:0] last_idx;
   logic [1:0] rd_idx;
   logic [1:0] wr_idx;

   assign io_stall = (mem_a_q[17:16] == 2'b11) && io_buffer_full;
   assign last_idx = len_q - 3'd1;
   assign rd_idx   = 2'(cnt_q - 3'd1);
   assign wr_idx   = 2'(cnt_q + 3'd1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      src_if_d   = src_if_q;
      wdata_d    = wdata_q;
      res_d      = res_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = mem_wr_q;
      lsb_r_d    = lsb_r_q;
      lsb_done_d = lsb_done_q;
      if_data_d  = if_data_q;
      if_done_d  = if_done_q;
      case (state_q)
         S_IDLE: begin
            if (!rollback && lsb_en) begin
               src_if_d   = 1'b0;
               mem_a_d    = lsb_a;
               len_d      = lsb_l;
               wdata_d    = lsb_w;
               mem_dout_d = lsb_w[7:0];
               mem_wr_d   = lsb_wr;
               cnt_d      = 3'd0;
               res_d      = '0;
               state_d    = lsb_wr ? S_WRITE : S_READ;
            end else if (!rollback && if_en) begin
               src_if_d = 1'b1;
               mem_a_d  = if_a;
               len_d    = 3'd4;
               mem_wr_d = 1'b0;
               cnt_d    = 3'd0;
               res_d    = '0;
               state_d  = S_READ;
            end
         end
         S_READ: begin
            if (src_if_q && rollback) begin
               cnt_d   = 3'd0;
               state_d = S_IDLE;
            end else begin
               // mem_din carries the byte addressed in the previous cycle
               if (cnt_q != 3'd0) res_d[{rd_idx, 3'b000} +: 8] = mem_din;
               if (cnt_q == len_q) begin
                  state_d = S_DONE;
                  if (src_if_q) begin
                     if_data_d = res_d;
                     if_done_d = 1'b1;
                  end else begin
                     lsb_r_d    = res_d;
                     lsb_done_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q != last_idx) mem_a_d = mem_a_q + ADDR_W'(1);
               end
            end
         end
         S_WRITE: begin
            if (!io_stall) begin
               if (cnt_q == last_idx) begin
                  mem_wr_d   = 1'b0;
                  lsb_done_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  cnt_d      = cnt_q + 3'd1;
                  mem_a_d    = mem_a_q + ADDR_W'(1);
                  mem_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
               end
            end
         end
         default: begin
            lsb_done_d = 1'b0;
            if_done_d  = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         src_if_q   <= 1'b0;
         wdata_q    <= '0;
         res_q      <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
         lsb_r_q    <= '0;
         lsb_done_q <= 1'b0;
         if_data_q  <= '0;
         if_done_q  <= 1'b0;
      end else if (rdy) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         src_if_q   <= src_if_d;
         wdata_q    <= wdata_d;
         res_q      <= res_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
         lsb_r_q    <= lsb_r_d;
         lsb_done_q <= lsb_done_d;
         if_data_q  <= if_data_d;
         if_done_q  <= if_done_d;
      end
   end

   // a frozen or IO-stalled cycle must never strobe the bus
   assign mem_wr   = mem_wr_q && rdy && !io_stall;
   assign mem_a    = mem_a_q;
   assign mem_dout = mem_dout_q;
   assign lsb_r    = lsb_r_q;
   assign lsb_done = lsb_done_q;
   assign if_data  = if_data_q;
   assign if_done  = if_done_q && !rollback;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder for the load/store unit's memory request port, and for the instruction fetcher.
- Accepts one request at a time and serializes it into byte-wide accesses on the external RAM/IO bus.
- Returns the assembled 32-bit result, or the completion of a store, as a one-cycle done pulse.
- Sits between LSB/IFetch and the top-level RAM interface.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; must equal 4 bytes.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  pipeline flush
- lsb_en  in  1  LSB request valid; held high until lsb_done
- lsb_wr  in  1  1=store, 0=load
- lsb_a  in  32  start byte address
- lsb_l  in  3  length in bytes: 1, 2 or 4
- lsb_w  in  32  store data, little-endian
- lsb_r  out  32  load result; unused high bytes are 0
- lsb_done  out  1  one-cycle completion pulse
- if_en  in  1  fetch request valid; held until if_done
- if_a  in  32  fetch address
- if_data  out  32  fetched instruction word
- if_done  out  1  one-cycle completion pulse
- mem_din  in  8  RAM read byte; valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1=write this cycle
- io_buffer_full  in  1  IO output buffer full

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0 (mem_a, mem_dout, mem_wr, lsb_r, lsb_done, if_data, if_done). State=IDLE, counters=0. Reset mid-transfer aborts with no done pulse.
- rdy=0:
  - All registers hold.
  - mem_wr is driven 0.
  - Done pulses do not extend; a done registered high stays high until the next rdy=1 edge.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - lsb_en has priority over if_en.
  - Latch source, address, length (if: 4), write flag and write data.
  - Go to READ or WRITE; clear the byte counter.
- READ (length L):
  - Cycle k (k=0..L-1): mem_a = addr+k, mem_wr=0.
  - The byte on mem_din in cycle k+1 is stored into result bits [8k+7:8k].
  - One extra cycle captures the last byte, with mem_a held at the last address.
  - The final capture edge sets the done pulse and goes to DONE.
  - Load latency: the done pulse is high in cycle L+2 after the accepting edge.
- WRITE (length L):
  - Cycle k: mem_a = addr+k, mem_dout = lsb_w[8k+7:8k], mem_wr=1.
  - Done is set on the edge after byte L-1 (latency L+1).
- IO stall:
  - Applies when the address has [17:16]==2'b11, the access is a write, and io_buffer_full=1.
  - Drive mem_wr=0 and hold the counter; resume when the buffer is no longer full.
  - IO reads are never stalled.
- DONE:
  - lsb_done or if_done is high for exactly this cycle, with the result valid.
  - Next state is IDLE.
  - IDLE does not re-accept on the edge ending DONE, because the requester drops its enable on that edge.
- Rollback:
  - If serving an ifetch (READ or DONE): abort to IDLE next edge; if_done is forced 0.
  - LSB transfers are never aborted by rollback; they complete normally.
  - In IDLE with rollback=1: no new request is accepted that cycle.
- Address arithmetic wraps modulo 2^32. The counter is 3 bits and never exceeds 4.
- lsb_r and if_data hold their last value until the next completion.

Test Plan:
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44 → mem_a steps 0x100..0x103; lsb_done one pulse in cycle 6; lsb_r=0x44332211.
- SH at 0x204, lsb_w=0xAABBCCDD → writes 0xDD@0x204, 0xCC@0x205 with mem_wr=1 in cycles 1-2; lsb_done in cycle 3; no write to 0x206.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles → mem_wr=0 during the stall, then one write of the byte; lsb_done follows.
- lsb_en and if_en asserted in the same cycle → the LSB load is served first; the fetch starts after DONE plus one IDLE cycle; if_done follows.
- Rollback during a fetch at the 2nd byte → no if_done; IDLE next cycle. Rollback during an LSB store → the store still completes.
- Async rst asserted mid-LW → outputs are 0 immediately; after release, a new LB at 0x0 returns a 0-extended byte with lsb_done in cycle 3.
